// File: rtl/img_buf_param.sv
// ---------------------------------------------------------------------------
// img_buf_param
//
// Parametrised image buffer for the coprocessor: one simple-dual-port
// (1 write / 1 read) RAM of DEPTH rows x DATA_W bits with per-byte write
// enables, a registered read port qualified by rvalid, and a clear sequencer
// that zero-fills every row between frames.
//
// Parameters
//   DATA_W    row width in bits (multiple of 8)
//   ADDR_W    address width
//   DEPTH     rows implemented, 1 <= DEPTH <= 2**ADDR_W
//   INIT_FILE preload file name (contents X until written/cleared)
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset (control state only, not the RAM)
//   we/waddr/wbe/wdata   write strobe, row address, byte enables, data
//   re/raddr  read strobe and row address
//   rdata     registered read data (latency 1)
//   rvalid    rdata holds the result of the read issued the previous cycle
//   clr       pulse: start zero-fill of all DEPTH rows
//   busy      clear in progress; external reads/writes are ignored
//   clr_done  one-cycle pulse when the sweep finishes
//
// Build option
//   IMG_BUF_BYPASS_EN : a read and write of the same valid row in one cycle
//                       returns the merged new row (write-first). Without it
//                       the read returns the pre-write row (read-first).
// ---------------------------------------------------------------------------
module img_buf_param #(
  parameter int    DATA_W    = 512,
  parameter int    ADDR_W    = 9,
  parameter int    DEPTH     = 1 << ADDR_W,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  input  logic                clr,
  output logic                busy,
  output logic                clr_done
);

  localparam int                NBYTES   = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                rvalid_reg;
  logic                busy_reg;
  logic                clr_done_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   rd_row;
  logic                wr_ok;
  logic                rd_in_range;

  // Expand byte enables to a bit mask (used for the bypass merge).
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{wbe[gi]}};
    end
  endgenerate

  // Writes outside the implemented rows are dropped; rst_n keeps a write
  // from landing while the control logic is held in reset.
  assign wr_ok       = rst_n && (state_reg == IDLE) && we && ({1'b0, waddr} < DEPTH_L);
  assign rd_in_range = {1'b0, raddr} < DEPTH_L;

`ifdef IMG_BUF_BYPASS_EN
  assign rd_row = (wr_ok && (waddr == raddr)) ?
                  ((mem[raddr] & ~wmask) | (wdata & wmask)) : mem[raddr];
`else
  assign rd_row = mem[raddr];
`endif

  // RAM array: no reset so it maps onto block RAM. The clear sweep owns the
  // write port while the sequencer is in CLEAR.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[clr_cnt_reg] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read port and clear sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A read accepted alongside clr still completes.
          if (re) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_in_range ? rd_row : '0;
          end else begin
            rvalid_reg <= 1'b0;
          end
          if (clr) begin
            state_reg   <= CLEAR;
            busy_reg    <= 1'b1;
            clr_cnt_reg <= '0;
          end
        end
        CLEAR: begin
          rvalid_reg <= 1'b0;
          if (clr_cnt_reg == LAST_ROW) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b1;
            clr_cnt_reg  <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign busy     = busy_reg;
  assign clr_done = clr_done_reg;

endmodule

// File: tb/tb_img_buf_param.sv
// ---------------------------------------------------------------------------
// tb_img_buf_param
//
// Self-checking bench for img_buf_param. A full-depth instance (512 rows,
// 64-bit rows) is driven with directed and random traffic against a row
// array model; a partial-depth instance (300 rows, 32-bit rows) covers
// out-of-range addressing and a non power-of-two sweep.
// ---------------------------------------------------------------------------
module tb_img_buf_param;

  localparam int DW   = 64;
  localparam int AW   = 9;
  localparam int DEP  = 512;
  localparam int NB   = DW / 8;
  localparam int SDW  = 32;
  localparam int SDEP = 300;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // full-depth instance
  logic          we, re, clr;
  logic [AW-1:0] waddr, raddr;
  logic [NB-1:0] wbe;
  logic [DW-1:0] wdata, rdata;
  logic          rvalid, busy, clr_done;

  // partial-depth instance
  logic             s_we, s_re, s_clr;
  logic [AW-1:0]    s_waddr, s_raddr;
  logic [SDW/8-1:0] s_wbe;
  logic [SDW-1:0]   s_wdata, s_rdata;
  logic             s_rvalid, s_busy, s_clr_done;

  img_buf_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .clr(clr),
    .busy(busy), .clr_done(clr_done)
  );

  img_buf_param #(.DATA_W(SDW), .ADDR_W(AW), .DEPTH(SDEP)) dut_s (
    .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wbe(s_wbe), .wdata(s_wdata),
    .re(s_re), .raddr(s_raddr), .rdata(s_rdata), .rvalid(s_rvalid), .clr(s_clr),
    .busy(s_busy), .clr_done(s_clr_done)
  );

  // reference model of the full-depth instance
  logic [DW-1:0] model [DEP];
  logic [DW-1:0] exp_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One IDLE-state transaction on the full-depth instance.
  task automatic op(input logic w, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                    input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
    logic [DW-1:0] merged;
    we = w; waddr = wa; wbe = be; wdata = wd; re = r; raddr = ra;
    merged = model[wa];
    for (int b = 0; b < NB; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
    if (r) begin
      exp_rdata = model[ra];
`ifdef IMG_BUF_BYPASS_EN
      if (w && (wa == ra)) exp_rdata = merged;
`endif
    end
    if (w) model[wa] = merged;
    tick();
    we = 1'b0; re = 1'b0;
    check("rvalid", 64'(rvalid), 64'(r));
    check("rdata", 64'(rdata), 64'(exp_rdata));
    $display("op we=%0d waddr=%0d wbe=%h wdata=%h re=%0d raddr=%0d -> rvalid=%0d rdata=%h",
             w, wa, be, wd, r, ra, rvalid, rdata);
  endtask

  // Full zero-fill sweep; optional noise on we/re/clr while busy.
  task automatic clear_full(input bit noise);
    int n;
    logic [AW-1:0] r0;
    r0 = AW'($urandom_range(0, DEP - 1));
    exp_rdata = model[r0];
    clr = 1'b1; re = 1'b1; raddr = r0;
    tick();
    clr = 1'b0; re = 1'b0;
    check("clr_rd_rvalid", 64'(rvalid), 64'(1));
    check("clr_rd_rdata", 64'(rdata), 64'(exp_rdata));
    check("busy_rise", 64'(busy), 64'(1));
    n = 1;
    while (busy && n < DEP + 50) begin
      if (noise) begin
        we = 1'($urandom); waddr = AW'($urandom); wbe = '1; wdata = {$urandom, $urandom};
        re = 1'($urandom); raddr = AW'($urandom); clr = 1'($urandom);
      end
      tick();
      check("busy_rvalid", 64'(rvalid), 64'(0));
      if (busy) begin
        n++;
        check("clr_done_early", 64'(clr_done), 64'(0));
      end else begin
        check("clr_done_pulse", 64'(clr_done), 64'(1));
      end
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    check("busy_cycles", 64'(n), 64'(DEP));
    tick();
    check("clr_done_fall", 64'(clr_done), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
    for (int i = 0; i < DEP; i++) model[i] = '0;
    $display("clear noise=%0d busy_cycles=%0d", noise, n);
  endtask

  task automatic s_op(input logic w, input logic [AW-1:0] wa, input logic [SDW-1:0] wd,
                      input logic r, input logic [AW-1:0] ra, input logic [SDW-1:0] exp_d);
    s_we = w; s_waddr = wa; s_wbe = '1; s_wdata = wd; s_re = r; s_raddr = ra;
    tick();
    s_we = 1'b0; s_re = 1'b0;
    check("s_rvalid", 64'(s_rvalid), 64'(r));
    if (r) check("s_rdata", 64'(s_rdata), 64'(exp_d));
    $display("s_op we=%0d waddr=%0d re=%0d raddr=%0d -> rvalid=%0d rdata=%h",
             w, wa, r, ra, s_rvalid, s_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] pat_p, pat_q, pat_r;

    rst_n = 1'b0;
    we = 0; re = 0; clr = 0; waddr = '0; raddr = '0; wbe = '0; wdata = '0;
    s_we = 0; s_re = 0; s_clr = 0; s_waddr = '0; s_raddr = '0; s_wbe = '0; s_wdata = '0;
    exp_rdata = '0;
    #22;
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_clr_done", 64'(clr_done), 64'(0));
    check("s_rst_busy", 64'(s_busy), 64'(0));
    rst_n = 1'b1;
    tick();

    // Establish known contents with a first sweep.
    clear_full(1'b0);

    // Full and partial byte writes.
    op(1, 9'd5, '1, {8{8'hA5}}, 0, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd5);
    check("wr_full_lit", 64'(rdata), 64'hA5A5_A5A5_A5A5_A5A5);
    op(1, 9'd5, 8'h01, 64'h0000_0000_0000_00FF, 0, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd5);
    check("wr_byte0_lit", 64'(rdata), 64'hA5A5_A5A5_A5A5_A5FF);
    op(1, 9'd5, '0, 64'h1234_5678_9ABC_DEF0, 0, 9'd0);   // wbe=0: no change
    op(0, 9'd0, '0, '0, 0, 9'd0);                         // rdata holds
    op(0, 9'd0, '0, '0, 1, 9'd5);

    // Same-address read and write.
    op(1, 9'd7, '1, {8{8'h11}}, 0, 9'd0);
    op(1, 9'd7, '1, {8{8'h22}}, 1, 9'd7);
`ifdef IMG_BUF_BYPASS_EN
    check("same_addr_lit", 64'(rdata), {8{8'h22}});
`else
    check("same_addr_lit", 64'(rdata), {8{8'h11}});
`endif

    // Random traffic on a small address window to force collisions.
    for (int k = 0; k < 300; k++) begin
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 15));
      op(1'($urandom), wa, NB'($urandom), {$urandom, $urandom}, 1'($urandom), ra);
    end

    // Sweep with traffic and clr pulses while busy, then spot-check rows.
    clear_full(1'b1);
    op(0, 9'd0, '0, '0, 0, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd255);
    op(0, 9'd0, '0, '0, 1, 9'd511);
    for (int k = 0; k < 10; k++) op(0, 9'd0, '0, '0, 1, AW'($urandom));

    // Reset in the middle of a sweep.
    pat_p = {$urandom, $urandom} | 64'h1;
    pat_q = {$urandom, $urandom} | 64'h1;
    pat_r = {$urandom, $urandom} | 64'h1;
    op(1, 9'd300, '1, pat_p, 0, 9'd0);
    op(1, 9'd50, '1, pat_q, 0, 9'd0);
    op(1, 9'd100, '1, pat_r, 0, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd300);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("mid_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 100; k++) tick();
    check("mid_busy_100", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata", 64'(rdata), 64'(0));
    check("async_rvalid", 64'(rvalid), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    check("async_clr_done", 64'(clr_done), 64'(0));
    #3 rst_n = 1'b1;
    tick();
    exp_rdata = '0;
    for (int i = 0; i < 100; i++) model[i] = '0;
    $display("reset applied after 100 sweep cycles");
    op(0, 9'd0, '0, '0, 1, 9'd0);
    op(0, 9'd0, '0, '0, 1, 9'd50);
    op(0, 9'd0, '0, '0, 1, 9'd99);
    op(0, 9'd0, '0, '0, 1, 9'd100);
    op(0, 9'd0, '0, '0, 1, 9'd300);
    check("row300_kept", 64'(rdata), 64'(pat_p));
    check("busy_after_abort", 64'(busy), 64'(0));

    // Partial-depth instance: sweep length and out-of-range addressing.
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    n = 1;
    while (s_busy && n < SDEP + 50) begin
      tick();
      if (s_busy) n++;
      else check("s_clr_done_pulse", 64'(s_clr_done), 64'(1));
    end
    check("s_busy_cycles", 64'(n), 64'(SDEP));
    $display("s_clear busy_cycles=%0d", n);
    s_op(1, 9'd299, 32'hCAFE_F00D, 0, 9'd0, 32'h0);
    s_op(1, 9'd400, 32'hDEAD_BEEF, 0, 9'd0, 32'h0);
    s_op(0, 9'd0, 32'h0, 1, 9'd400, 32'h0);
    s_op(0, 9'd0, 32'h0, 1, 9'd299, 32'hCAFE_F00D);
    s_op(0, 9'd0, 32'h0, 1, 9'd144, 32'h0);
    s_op(0, 9'd0, 32'h0, 1, 9'd511, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
